// File: rtl/guess_pkg.sv
// rtl/guess_pkg.sv - shared types, constants and secret reduction for the guessing-game round controller
//
// Contents:
//   state_t         round FSM state encoding
//   hint_t          guess feedback encoding
//   RANGE_1D/2D     exclusive upper bound of the secret per digit count
//   TICKS_PER_DIGIT timer reload ticks per configured digit
//   norm_digits()   maps raw difficulty onto 1 or 2 digits
//   reduce_secret() folds a 7-bit source into the legal secret range
package guess_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_WIN  = 3'd3,
    ST_LOSE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    HINT_NONE = 2'b00,
    HINT_LOW  = 2'b01,
    HINT_HIGH = 2'b10,
    HINT_HIT  = 2'b11
  } hint_t;

  localparam int RANGE_1D        = 10;
  localparam int RANGE_2D        = 100;
  localparam int TICKS_PER_DIGIT = 30;

  // Only one and two digit games exist; 0 and 3 fold onto the nearest legal value.
  function automatic logic [1:0] norm_digits(input logic [1:0] d);
    logic [1:0] r;
    case (d)
      2'd0, 2'd1: r = 2'd1;
      default:    r = 2'd2;
    endcase
    return r;
  endfunction

  // A single conditional subtract suffices: the 1-digit source is at most 15
  // and the 2-digit source at most 127, so neither can exceed twice the range.
  function automatic logic [6:0] reduce_secret(input logic [6:0] x, input logic [1:0] dig);
    logic [6:0] v;
    if (dig == 2'd1) begin
      v = {3'b000, x[3:0]};
      if (v >= 7'(RANGE_1D)) v = v - 7'(RANGE_1D);
    end else begin
      v = x;
      if (v >= 7'(RANGE_2D)) v = v - 7'(RANGE_2D);
    end
    return v;
  endfunction

endpackage

// File: rtl/guess_round_ctrl_if.sv
// rtl/guess_round_ctrl_if.sv - player, timer and display signals of the round controller
//
// Signals:
//   start, difficulty, secret_ovr_en, secret_ovr  round start request and secret selection
//   guess_valid, guess                              player guess strobe and value
//   tm_counter                                      countdown value from the timer
//   tm_restart, tm_max_digit                        timer reload control
//   state, hint, tries, time_left, win, lose        round status to display logic
// Modports: master drives requests and the timer value; slave is the controller.
interface guess_round_ctrl_if;
  logic       start;
  logic [1:0] difficulty;
  logic       secret_ovr_en;
  logic [6:0] secret_ovr;
  logic       guess_valid;
  logic [6:0] guess;
  logic [6:0] tm_counter;
  logic       tm_restart;
  logic [1:0] tm_max_digit;
  logic [2:0] state;
  logic [1:0] hint;
  logic [3:0] tries;
  logic [6:0] time_left;
  logic       win;
  logic       lose;

  modport master (
    output start, difficulty, secret_ovr_en, secret_ovr, guess_valid, guess, tm_counter,
    input  tm_restart, tm_max_digit, state, hint, tries, time_left, win, lose
  );

  modport slave (
    input  start, difficulty, secret_ovr_en, secret_ovr, guess_valid, guess, tm_counter,
    output tm_restart, tm_max_digit, state, hint, tries, time_left, win, lose
  );
endinterface

// File: rtl/secret_lfsr.sv
// rtl/secret_lfsr.sv - free-running 7-bit LFSR (x^7+x^6+1) used as the random secret source
//
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset, loads SEED
//   lfsr_o  current LFSR state
module secret_lfsr #(
  parameter logic [6:0] SEED = 7'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [6:0] lfsr_o
);

  logic [6:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/guess_round_ctrl.sv
// rtl/guess_round_ctrl.sv - guessing-game round FSM: secret capture, guess evaluation, timer sequencing
//
// Ports:
//   clk      system clock
//   restart  asynchronous active-low reset of the whole block
//   bus      guess_round_ctrl_if.slave: start/secret selection, guesses, timer
//            counter in; timer control and round status out
module guess_round_ctrl
  import guess_pkg::*;
#(
  parameter int         MAX_TRIES = 8,
  parameter logic [6:0] LFSR_SEED = 7'h01
) (
  input  logic               clk,
  input  logic               restart,
  guess_round_ctrl_if.slave  bus
);

  logic [6:0] lfsr;

  secret_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (restart),
    .lfsr_o (lfsr)
  );

  state_t     state_q,     state_d;
  hint_t      hint_q,      hint_d;
  logic [3:0] tries_q,     tries_d;
  logic [6:0] time_left_q, time_left_d;
  logic [1:0] dig_q,       dig_d;
  logic [6:0] secret_q,    secret_d;
  logic       win_q,       win_d;
  logic       lose_q,      lose_d;

  logic [1:0] start_dig;
  logic [3:0] tries_inc;

  assign start_dig = norm_digits(bus.difficulty);
  assign tries_inc = tries_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    hint_d      = hint_q;
    tries_d     = tries_q;
    time_left_d = time_left_q;
    dig_d       = dig_q;
    secret_d    = secret_q;
    win_d       = win_q;
    lose_d      = lose_q;

    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (bus.start) begin
          state_d  = ST_LOAD;
          dig_d    = start_dig;
          secret_d = reduce_secret(bus.secret_ovr_en ? bus.secret_ovr : lfsr, start_dig);
          tries_d  = 4'd0;
          hint_d   = HINT_NONE;
          win_d    = 1'b0;
          lose_d   = 1'b0;
        end
      end

      ST_LOAD: state_d = ST_PLAY;

      ST_PLAY: begin
        // A correct guess beats both the try limit and an expired timer.
        if (bus.guess_valid && bus.guess == secret_q) begin
          hint_d      = HINT_HIT;
          state_d     = ST_WIN;
          win_d       = 1'b1;
          time_left_d = bus.tm_counter;
        end else if (bus.guess_valid) begin
          hint_d  = (bus.guess < secret_q) ? HINT_LOW : HINT_HIGH;
          tries_d = tries_inc;
          if (tries_inc == 4'(MAX_TRIES)) begin
            state_d     = ST_LOSE;
            lose_d      = 1'b1;
            time_left_d = bus.tm_counter;
          end
        end else if (bus.tm_counter == 7'd0) begin
          state_d     = ST_LOSE;
          lose_d      = 1'b1;
          time_left_d = bus.tm_counter;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      state_q     <= ST_IDLE;
      hint_q      <= HINT_NONE;
      tries_q     <= 4'd0;
      time_left_q <= 7'd0;
      dig_q       <= 2'd1;
      secret_q    <= 7'd0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hint_q      <= hint_d;
      tries_q     <= tries_d;
      time_left_q <= time_left_d;
      dig_q       <= dig_d;
      secret_q    <= secret_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
    end
  end

  // The timer is held in reload until the round is actually running.
  assign bus.tm_restart   = !(state_q == ST_IDLE || state_q == ST_LOAD);
  assign bus.tm_max_digit = dig_q;
  assign bus.state        = state_q;
  assign bus.hint         = hint_q;
  assign bus.tries        = tries_q;
  assign bus.time_left    = time_left_q;
  assign bus.win          = win_q;
  assign bus.lose         = lose_q;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// tb/tb_guess_round_ctrl.sv - self-checking bench for guess_round_ctrl with a countdown timer stand-in
module tb_guess_round_ctrl;

  logic clk = 1'b0;
  logic restart = 1'b0;
  always #5 clk = ~clk;

  guess_round_ctrl_if bus();

  guess_round_ctrl dut (
    .clk     (clk),
    .restart (restart),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Countdown timer as seen by the controller.
  always @(posedge clk) begin
    if (!bus.tm_restart) bus.tm_counter <= 7'(30 * bus.tm_max_digit);
    else if (bus.tm_counter != 7'd0) bus.tm_counter <= bus.tm_counter - 7'd1;
  end

  // Reference model: round rules applied per clock edge to integer game state.
  int m_state = 0, m_hint = 0, m_tries = 0, m_tl = 0, m_maxd = 1, m_secret = 0, m_lfsr = 1;
  int m_dig, m_src;

  always @(posedge clk or negedge restart) begin
    if (!restart) begin
      m_state = 0; m_hint = 0; m_tries = 0; m_tl = 0; m_maxd = 1; m_lfsr = 1;
    end else begin
      if (m_state == 0 || m_state == 3 || m_state == 4) begin
        if (bus.start) begin
          m_dig    = (bus.difficulty == 0) ? 1 : (bus.difficulty == 3) ? 2 : int'(bus.difficulty);
          m_src    = bus.secret_ovr_en ? int'(bus.secret_ovr) : m_lfsr;
          m_secret = (m_dig == 1) ? (m_src % 16) % 10 : m_src % 100;
          m_maxd   = m_dig;
          m_tries  = 0;
          m_hint   = 0;
          m_state  = 1;
        end
      end else if (m_state == 1) begin
        m_state = 2;
      end else begin
        if (bus.guess_valid && int'(bus.guess) == m_secret) begin
          m_hint = 3; m_state = 3; m_tl = bus.tm_counter;
        end else if (bus.guess_valid) begin
          m_hint  = (int'(bus.guess) < m_secret) ? 1 : 2;
          m_tries = m_tries + 1;
          if (m_tries == 8) begin m_state = 4; m_tl = bus.tm_counter; end
        end else if (bus.tm_counter == 0) begin
          m_state = 4; m_tl = 0;
        end
      end
      m_lfsr = ((m_lfsr * 2) + (((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1)) % 128;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_state",      bus.state,        m_state);
      chk("cyc_hint",       bus.hint,         m_hint);
      chk("cyc_tries",      bus.tries,        m_tries);
      chk("cyc_time_left",  bus.time_left,    m_tl);
      chk("cyc_max_digit",  bus.tm_max_digit, m_maxd);
      chk("cyc_win",        bus.win,          32'(m_state == 3));
      chk("cyc_lose",       bus.lose,         32'(m_state == 4));
      chk("cyc_tm_restart", bus.tm_restart,   32'(m_state >= 2));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Leaves the bench in the first PLAY cycle.
  task automatic start_round(input logic [1:0] d, input logic en, input logic [6:0] ovr);
    bus.difficulty    = d;
    bus.secret_ovr_en = en;
    bus.secret_ovr    = ovr;
    bus.start         = 1'b1;
    step();
    bus.start = 1'b0;
    step();
  endtask

  task automatic do_guess(input logic [6:0] g);
    bus.guess_valid = 1'b1;
    bus.guess       = g;
    step();
    bus.guess_valid = 1'b0;
  endtask

  int n;
  logic [6:0] tl_keep;
  logic [6:0] try_vals [8] = '{7'd127, 7'd0, 7'd19, 7'd21, 7'd99, 7'd100, 7'd1, 7'd50};
  logic [1:0] try_hint [8] = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

  initial begin
    bus.start = 1'b0; bus.difficulty = 2'd0; bus.secret_ovr_en = 1'b0; bus.secret_ovr = 7'd0;
    bus.guess_valid = 1'b0; bus.guess = 7'd0;
    cmp_en = 1'b1;
    repeat (3) step();
    chk("rst_state",      bus.state,        0);
    chk("rst_tm_restart", bus.tm_restart,   0);
    chk("rst_tries",      bus.tries,        0);
    chk("rst_hint",       bus.hint,         0);
    chk("rst_max_digit",  bus.tm_max_digit, 1);
    restart = 1'b1;
    step();

    // Win path
    start_round(2'd2, 1'b1, 7'd42);
    chk("win_play",      bus.state, 2);
    do_guess(7'd50);
    chk("win_g1_hint",   bus.hint,  2'b10);
    chk("win_g1_tries",  bus.tries, 1);
    do_guess(7'd30);
    chk("win_g2_hint",   bus.hint,  2'b01);
    chk("win_g2_tries",  bus.tries, 2);
    do_guess(7'd42);
    chk("win_state",     bus.state, 3);
    chk("win_flag",      bus.win,   1);
    chk("win_hint",      bus.hint,  2'b11);
    chk("win_tries",     bus.tries, 2);
    chk("win_time_left", bus.time_left, 58);
    do_guess(7'd1);
    chk("win_hold_hint", bus.hint,  2'b11);

    // Timeout
    start_round(2'd1, 1'b1, 7'd3);
    n = 0;
    while (!bus.lose && n < 40) begin step(); n++; end
    chk("to_cycles",    n, 31);
    chk("to_state",     bus.state, 4);
    chk("to_time_left", bus.time_left, 0);

    // Out of tries, with 2-digit reduction (120 -> 20) and an above-range guess
    start_round(2'd2, 1'b1, 7'd120);
    for (int i = 0; i < 8; i++) begin
      do_guess(try_vals[i]);
      chk("ot_hint", bus.hint, try_hint[i]);
      chk("ot_tries", bus.tries, i + 1);
    end
    chk("ot_state",     bus.state, 4);
    chk("ot_time_left", bus.time_left, 53);
    tl_keep = bus.time_left;
    do_guess(7'd20);
    chk("ot_9th_state", bus.state, 4);
    chk("ot_9th_tries", bus.tries, 8);
    chk("ot_9th_hint",  bus.hint,  2'b10);
    chk("ot_9th_tl",    bus.time_left, tl_keep);

    // Correct guess racing the timer reaching zero
    start_round(2'd1, 1'b1, 7'd7);
    n = 0;
    while (bus.tm_counter != 7'd0 && n < 40) begin step(); n++; end
    chk("race_wait", 32'(n < 40), 1);
    chk("race_still_play", bus.state, 2);
    do_guess(7'd7);
    chk("race_state",     bus.state, 3);
    chk("race_time_left", bus.time_left, 0);

    // Mid-round asynchronous reset
    start_round(2'd2, 1'b1, 7'd42);
    step(); step();
    #2 restart = 1'b0;
    #1;
    chk("mr_state",      bus.state, 0);
    chk("mr_tm_restart", bus.tm_restart, 0);
    step();
    restart = 1'b1;
    step();

    // difficulty 0 treated as one digit, 15 reduces to 5
    start_round(2'd0, 1'b1, 7'd15);
    chk("rr_max_digit", bus.tm_max_digit, 1);
    do_guess(7'd5);
    chk("rr_win", bus.win, 1);

    // LFSR-sourced secret, difficulty 3 treated as two digits, start ignored in PLAY
    start_round(2'd3, 1'b0, 7'd0);
    chk("lf_max_digit", bus.tm_max_digit, 2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("lf_start_ign", bus.state, 2);
    do_guess(7'(m_secret));
    chk("lf_win", bus.win, 1);

    step(); step();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
